// File: rtl/axi_ic_pkg.sv
// axi_ic_pkg: shared types and helpers for the AXI interconnect arbiters
package axi_ic_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    localparam int AXI_LEN_W = 4;
    localparam logic [1:0] BURST_INCR = 2'b01;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, scans ptr+1 .. ptr+M (mod M)
module rr_pick
    import axi_ic_pkg::*;
#(
    parameter int M      = 2,
    parameter int MIDX_W = idx_w(M)
) (
    input  logic [M-1:0]      req,
    input  logic [MIDX_W-1:0] ptr,
    output logic [M-1:0]      gnt,
    output logic [MIDX_W-1:0] idx,
    output logic              any
);
    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 1; i <= M; i++) begin
            j = (int'(ptr) + i) % M;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = MIDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one AXI read port among M masters,
// one burst in flight, grant held until the last data beat.
module axi_rd_arbiter
    import axi_ic_pkg::*;
#(
    parameter int M          = 2,
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int MIDX_W     = idx_w(M)
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [M-1:0]            m_arvalid,
    output logic [M-1:0]            m_arready,
    input  logic [M*ID_WIDTH-1:0]   m_arid,
    input  logic [M*ADDR_WIDTH-1:0] m_araddr,
    input  logic [M*AXI_LEN_W-1:0]  m_arlen,
    output logic [M-1:0]            m_rvalid,
    input  logic [M-1:0]            m_rready,
    output logic [BUS_WIDTH-1:0]    m_rdata,
    output logic [ID_WIDTH-1:0]     m_rid,
    output logic                    m_rlast,
    output logic                    s_arvalid,
    input  logic                    s_arready,
    output logic [ID_WIDTH-1:0]     s_arid,
    output logic [ADDR_WIDTH-1:0]   s_araddr,
    output logic [AXI_LEN_W-1:0]    s_arlen,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    input  logic [BUS_WIDTH-1:0]    s_rdata,
    input  logic [ID_WIDTH-1:0]     s_rid,
    input  logic                    s_rlast,
    output logic [MIDX_W-1:0]       grant_idx,
    output logic                    busy,
    output logic                    len_err
);
    state_t                 state;
    logic [MIDX_W-1:0]      rr_ptr;
    logic [AXI_LEN_W-1:0]   cnt;
    logic [M-1:0]           pick_gnt;
    logic [MIDX_W-1:0]      pick_idx;
    logic                   pick_any;
    logic                   beat;

    rr_pick #(.M(M), .MIDX_W(MIDX_W)) u_pick (
        .req(m_arvalid),
        .ptr(rr_ptr),
        .gnt(pick_gnt),
        .idx(pick_idx),
        .any(pick_any)
    );

    // gate with clr so no accept is offered while reset is held
    assign m_arready = (state == IDLE && !clr) ? pick_gnt : '0;
    assign s_arvalid = state == ADDR;
    assign busy      = state != IDLE;
    assign s_rready  = state == DATA && m_rready[grant_idx];
    assign beat      = s_rvalid && s_rready;
    assign m_rdata   = s_rdata;
    assign m_rid     = s_rid;
    assign m_rlast   = s_rlast;

    for (genvar g = 0; g < M; g++) begin : g_rv
        assign m_rvalid[g] = state == DATA && grant_idx == MIDX_W'(g) && s_rvalid;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= MIDX_W'(M - 1);
            cnt       <= '0;
            len_err   <= 1'b0;
            s_arid    <= '0;
            s_araddr  <= '0;
            s_arlen   <= '0;
        end else begin
            case (state)
                IDLE: if (pick_any) begin
                    s_arid    <= m_arid[pick_idx*ID_WIDTH +: ID_WIDTH];
                    s_araddr  <= m_araddr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    s_arlen   <= m_arlen[pick_idx*AXI_LEN_W +: AXI_LEN_W];
                    grant_idx <= pick_idx;
                    state     <= ADDR;
                end
                ADDR: if (s_arready) begin
                    cnt   <= s_arlen;
                    state <= DATA;
                end
                DATA: if (beat) begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    // early last ends the burst; missing last keeps waiting
                    if (s_rlast) begin
                        state  <= IDLE;
                        rr_ptr <= grant_idx;
                        if (cnt != '0) len_err <= 1'b1;
                    end else if (cnt == '0) begin
                        len_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: scenario tasks with a scoreboard of expected grants and data beats
module tb_axi_rd_arbiter;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [1:0]  m_arvalid = '0, m_arready, m_rvalid, m_rready = 2'b11;
    logic [1:0]  m_arid = '0;
    logic [63:0] m_araddr = '0;
    logic [7:0]  m_arlen = '0;
    logic [31:0] m_rdata, s_araddr, s_rdata = '0;
    logic [0:0]  m_rid, s_arid, s_rid = '0;
    logic        m_rlast, s_arvalid, s_arready = 1'b1, s_rvalid = 1'b0, s_rready, s_rlast = 1'b0;
    logic [3:0]  s_arlen;
    logic [0:0]  grant_idx;
    logic        busy, len_err;

    typedef struct {logic [1:0] rv; logic [31:0] d; logic l;} beat_t;
    beat_t exp_q[$];
    int    grant_q[$];
    int    n_cmp = 0, n_bad = 0;

    axi_rd_arbiter #(.M(2), .ID_WIDTH(1), .ADDR_WIDTH(32), .BUS_WIDTH(32)) dut (
        .clk(clk), .clr(clr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rid(m_rid), .m_rlast(m_rlast), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
        .s_rlast(s_rlast), .grant_idx(grant_idx), .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        clr = 1'b1; m_arvalid = '0; s_rvalid = 1'b0; s_rlast = 1'b0; s_arready = 1'b1; m_rready = 2'b11;
        tick(); tick();
        clr = 1'b0;
        exp_q.delete(); grant_q.delete();
    endtask

    task automatic set_req(input int g, input logic [31:0] a, input logic [3:0] l, input logic id);
        m_araddr[g*32 +: 32] = a; m_arlen[g*4 +: 4] = l; m_arid[g] = id;
    endtask

    task automatic drive_beat(input int g, input logic [31:0] d, input logic l);
        beat_t e;
        s_rvalid = 1'b1; s_rdata = d; s_rlast = l;
        e.rv = 2'(1 << g); e.d = d; e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        clr = 1'b1; m_arvalid = 2'b11;
        set_req(0, 32'h1, 4'd0, 1'b0); set_req(1, 32'h2, 4'd0, 1'b1);
        tick(); tick();
        @(negedge clk);
        n_cmp++;
        if ({m_arready, m_rvalid, s_arvalid, s_rready, busy, len_err, grant_idx} !== '0 || s_araddr !== '0 || s_arlen !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got arready=%b rvalid=%b arvalid=%b rready=%b busy=%b len_err=%b gidx=%0d addr=%h len=%0d required all 0",
                     m_arready, m_rvalid, s_arvalid, s_rready, busy, len_err, grant_idx, s_araddr, s_arlen);
        end
        tick(); clr = 1'b0;
        grant_q.push_back(0);
        @(negedge clk);
        n_cmp++;
        if (m_arready !== 2'b01) begin n_bad++; $display("FAIL reset_first_grant: got m_arready=%b required 01", m_arready); end
        tick(); m_arvalid = '0;
        @(negedge clk);
        n_cmp++;
        if (s_arvalid !== 1'b1 || grant_idx !== 1'(grant_q.pop_front()) || s_araddr !== 32'h1) begin
            n_bad++; $display("FAIL reset_first_addr: got arvalid=%b gidx=%0d addr=%h required 1/0/1", s_arvalid, grant_idx, s_araddr);
        end
        do_reset();
    endtask

    task automatic test_single();
        beat_t e;
        do_reset();
        set_req(0, 32'h0A, 4'd3, 1'b1); m_arvalid = 2'b01;
        grant_q.push_back(0);
        @(negedge clk);
        n_cmp++;
        if (m_arready !== 2'b01 || s_arvalid !== 1'b0) begin n_bad++; $display("FAIL single_arready: got arready=%b arvalid=%b required 01/0", m_arready, s_arvalid); end
        tick(); m_arvalid = '0;
        @(negedge clk);
        n_cmp++;
        if (s_arvalid !== 1'b1 || s_araddr !== 32'h0A || s_arlen !== 4'd3 || s_arid !== 1'b1 || grant_idx !== 1'(grant_q.pop_front()) || m_arready !== 2'b00) begin
            n_bad++; $display("FAIL single_addr: got arvalid=%b addr=%h len=%0d id=%b gidx=%0d arready=%b required 1/0a/3/1/0/00",
                              s_arvalid, s_araddr, s_arlen, s_arid, grant_idx, m_arready);
        end
        tick();
        for (int b = 0; b < 4; b++) begin
            drive_beat(0, 32'h100 + b, b == 3);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (m_rvalid !== e.rv || m_rdata !== e.d || m_rlast !== e.l || busy !== 1'b1) begin
                n_bad++; $display("FAIL single_beat%0d: got rvalid=%b data=%h last=%b busy=%b required %b/%h/%b/1", b, m_rvalid, m_rdata, m_rlast, busy, e.rv, e.d, e.l);
            end
            tick();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || len_err !== 1'b0) begin n_bad++; $display("FAIL single_end: got busy=%b len_err=%b required 0/0", busy, len_err); end
    endtask

    task automatic test_contention();
        beat_t e;
        int g;
        do_reset();
        set_req(0, 32'h10, 4'd1, 1'b0); set_req(1, 32'h20, 4'd1, 1'b1);
        m_arvalid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            grant_q.push_back(g);
            @(negedge clk);
            n_cmp++;
            if (m_arready !== 2'(1 << g)) begin n_bad++; $display("FAIL contention_arready%0d: got %b required %b", k, m_arready, 2'(1 << g)); end
            tick();
            @(negedge clk);
            n_cmp++;
            if (s_arvalid !== 1'b1 || grant_idx !== 1'(grant_q.pop_front()) || s_araddr !== (g == 1 ? 32'h20 : 32'h10)) begin
                n_bad++; $display("FAIL contention_grant%0d: got arvalid=%b gidx=%0d addr=%h required 1/%0d", k, s_arvalid, grant_idx, s_araddr, g);
            end
            tick();
            for (int b = 0; b < 2; b++) begin
                drive_beat(g, 32'h200 + k*2 + b, b == 1);
                @(negedge clk);
                e = exp_q.pop_front();
                n_cmp++;
                if (m_rvalid !== e.rv || m_rdata !== e.d || m_rlast !== e.l) begin
                    n_bad++; $display("FAIL contention_beat%0d_%0d: got rvalid=%b data=%h last=%b required %b/%h/%b", k, b, m_rvalid, m_rdata, m_rlast, e.rv, e.d, e.l);
                end
                tick();
            end
            s_rvalid = 1'b0; s_rlast = 1'b0;
        end
        m_arvalid = '0;
    endtask

    task automatic test_back_to_back();
        beat_t e;
        do_reset();
        set_req(1, 32'h60, 4'd0, 1'b1); m_arvalid = 2'b10;
        for (int k = 0; k < 2; k++) begin
            grant_q.push_back(1);
            @(negedge clk);
            n_cmp++;
            if (m_arready !== 2'b10 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle%0d: got arready=%b busy=%b required 10/0", k, m_arready, busy); end
            tick();
            @(negedge clk);
            n_cmp++;
            if (grant_idx !== 1'(grant_q.pop_front()) || s_arvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_grant%0d: got gidx=%0d arvalid=%b required 1/1", k, grant_idx, s_arvalid); end
            tick();
            drive_beat(1, 32'h300 + k, 1'b1);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (m_rvalid !== e.rv || m_rdata !== e.d) begin n_bad++; $display("FAIL b2b_beat%0d: got rvalid=%b data=%h required %b/%h", k, m_rvalid, m_rdata, e.rv, e.d); end
            tick();
            s_rvalid = 1'b0; s_rlast = 1'b0;
        end
        m_arvalid = '0;
    endtask

    task automatic test_stalls();
        beat_t e;
        do_reset();
        set_req(1, 32'h30, 4'd3, 1'b0); m_arvalid = 2'b10; s_arready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (m_arready !== 2'b10) begin n_bad++; $display("FAIL stall_arready: got %b required 10", m_arready); end
        tick(); m_arvalid = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (s_arvalid !== 1'b1 || s_araddr !== 32'h30 || s_arlen !== 4'd3) begin
                n_bad++; $display("FAIL stall_ar_hold%0d: got arvalid=%b addr=%h len=%0d required 1/30/3", c, s_arvalid, s_araddr, s_arlen);
            end
            tick();
        end
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            drive_beat(1, 32'h400 + b, b == 3);
            if (b == 2) begin
                m_rready = 2'b01;
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (s_rready !== 1'b0 || m_rvalid !== 2'b10) begin n_bad++; $display("FAIL stall_r%0d: got rready=%b rvalid=%b required 0/10", c, s_rready, m_rvalid); end
                    tick();
                end
                m_rready = 2'b11;
            end
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (s_rready !== 1'b1 || m_rvalid !== e.rv || m_rdata !== e.d || m_rlast !== e.l) begin
                n_bad++; $display("FAIL stall_beat%0d: got rready=%b rvalid=%b data=%h last=%b required 1/%b/%h/%b", b, s_rready, m_rvalid, m_rdata, m_rlast, e.rv, e.d, e.l);
            end
            tick();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0; s_arready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || len_err !== 1'b0) begin n_bad++; $display("FAIL stall_end: got busy=%b len_err=%b required 0/0", busy, len_err); end
    endtask

    task automatic test_errors();
        beat_t e;
        do_reset();
        set_req(0, 32'h70, 4'd3, 1'b0); m_arvalid = 2'b01;
        tick(); m_arvalid = '0; tick();
        for (int b = 0; b < 2; b++) begin
            drive_beat(0, 32'h500 + b, b == 1);
            @(negedge clk); e = exp_q.pop_front();
            n_cmp++;
            if (m_rvalid !== e.rv || m_rdata !== e.d) begin n_bad++; $display("FAIL early_beat%0d: got rvalid=%b data=%h required %b/%h", b, m_rvalid, m_rdata, e.rv, e.d); end
            tick();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || len_err !== 1'b1) begin n_bad++; $display("FAIL early_last: got busy=%b len_err=%b required 0/1", busy, len_err); end
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (len_err !== 1'b0) begin n_bad++; $display("FAIL len_err_clear: got %b required 0", len_err); end
        set_req(0, 32'h80, 4'd1, 1'b0); m_arvalid = 2'b01;
        tick(); m_arvalid = '0; tick();
        for (int b = 0; b < 3; b++) begin
            drive_beat(0, 32'h600 + b, b == 2);
            @(negedge clk); e = exp_q.pop_front();
            n_cmp++;
            if (m_rvalid !== e.rv || m_rdata !== e.d || len_err !== (b == 2) || busy !== 1'b1) begin
                n_bad++; $display("FAIL late_beat%0d: got rvalid=%b data=%h len_err=%b busy=%b required %b/%h/%b/1", b, m_rvalid, m_rdata, len_err, busy, e.rv, e.d, b == 2);
            end
            tick();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || len_err !== 1'b1) begin n_bad++; $display("FAIL late_end: got busy=%b len_err=%b required 0/1", busy, len_err); end
    endtask

    task automatic test_async_reset();
        beat_t e;
        do_reset();
        set_req(0, 32'h40, 4'd3, 1'b0); m_arvalid = 2'b01;
        tick(); m_arvalid = '0; tick();
        drive_beat(0, 32'h700, 1'b0);
        @(negedge clk); e = exp_q.pop_front();
        n_cmp++;
        if (m_rvalid !== e.rv || m_rdata !== e.d) begin n_bad++; $display("FAIL async_beat0: got rvalid=%b data=%h required %b/%h", m_rvalid, m_rdata, e.rv, e.d); end
        tick();
        s_rvalid = 1'b1; s_rdata = 32'h701;
        #2 clr = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || s_rready !== 1'b0 || m_rvalid !== 2'b00 || s_arvalid !== 1'b0) begin
            n_bad++; $display("FAIL async_clr: got busy=%b rready=%b rvalid=%b arvalid=%b required 0/0/00/0", busy, s_rready, m_rvalid, s_arvalid);
        end
        #1 clr = 1'b0; s_rvalid = 1'b0;
        tick();
        set_req(0, 32'h50, 4'd0, 1'b1); m_arvalid = 2'b01;
        @(negedge clk);
        n_cmp++;
        if (m_arready !== 2'b01) begin n_bad++; $display("FAIL async_regrant: got arready=%b required 01", m_arready); end
        tick(); m_arvalid = '0;
        @(negedge clk);
        n_cmp++;
        if (s_arvalid !== 1'b1 || s_araddr !== 32'h50 || grant_idx !== 1'b0) begin
            n_bad++; $display("FAIL async_addr: got arvalid=%b addr=%h gidx=%0d required 1/50/0", s_arvalid, s_araddr, grant_idx);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_stalls();
        test_errors();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
